// File: rtl/y86_run_ctrl_if.sv
// Bus between the Y86 datapath (master) and the PC/run controller (slave).
// Valid/ready: none; every input is a level sampled on each rising edge, and every output is registered state.
interface y86_run_ctrl_if #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32,
  parameter int NUM_BP = 2
);
  logic                     start_i;
  logic                     resume_i;
  logic                     stall_i;
  logic [ADDR_W-1:0]        npc_i;
  logic [3:0]               stat_i;
  logic [NUM_BP-1:0]        bp_en_i;
  logic [NUM_BP*ADDR_W-1:0] bp_addr_i;
  logic [ADDR_W-1:0]        PC_o;
  logic [1:0]               state_o;
  logic                     run_o;
  logic                     commit_o;
  logic [3:0]               halt_stat_o;
  logic [CNT_W-1:0]         cycle_cnt_o;
  logic [CNT_W-1:0]         instr_cnt_o;

  modport master (
    output start_i, resume_i, stall_i, npc_i, stat_i, bp_en_i, bp_addr_i,
    input  PC_o, state_o, run_o, commit_o, halt_stat_o, cycle_cnt_o, instr_cnt_o
  );

  modport slave (
    input  start_i, resume_i, stall_i, npc_i, stat_i, bp_en_i, bp_addr_i,
    output PC_o, state_o, run_o, commit_o, halt_stat_o, cycle_cnt_o, instr_cnt_o
  );
endinterface

// File: rtl/y86_run_ctrl.sv
// PC register and IDLE/RUN/BREAK/HALT run controller for the Y86 single-cycle core.
// Optional RUN-cycle watchdog enabled by defining Y86_WATCHDOG_EN.
module y86_run_ctrl #(
  parameter int                ADDR_W     = 64,
  parameter int                CNT_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                NUM_BP     = 2,
  parameter int                WDOG_LIMIT = 1000
) (
  input logic             clk_i,
  input logic             rst_n_i,
  y86_run_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_BREAK = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  localparam logic [3:0] STAT_AOK  = 4'h1;
  localparam logic [3:0] STAT_WDOG = 4'h5;

`ifdef Y86_WATCHDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              commit_q;
  logic [3:0]        halt_stat_q;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;
  logic              bp_hit;
  logic              wdog_hit;

  // Counters stick at all-ones instead of wrapping.
  assign cycle_cnt_d = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
  assign instr_cnt_d = (&instr_cnt_q) ? instr_cnt_q : instr_cnt_q + CNT_W'(1);

  // With the watchdog compiled out this folds to a constant 0.
  assign wdog_hit = WDOG_ON && (cycle_cnt_d == CNT_W'(WDOG_LIMIT));

  always_comb begin
    bp_hit = 1'b0;
    for (int k = 0; k < NUM_BP; k++) begin
      if (bus.bp_en_i[k] && (bus.bp_addr_i[k*ADDR_W +: ADDR_W] == bus.npc_i)) bp_hit = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      commit_q    <= 1'b0;
      halt_stat_q <= 4'h0;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      commit_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start_i) state_q <= S_RUN;
        end
        S_RUN: begin
          if (bus.stall_i) begin
            cycle_cnt_q <= cycle_cnt_d;
            if (wdog_hit) begin
              state_q     <= S_HALT;
              halt_stat_q <= STAT_WDOG;
            end
          end else if (bus.stat_i != STAT_AOK) begin
            state_q     <= S_HALT;
            halt_stat_q <= bus.stat_i;
          end else if (wdog_hit) begin
            cycle_cnt_q <= cycle_cnt_d;
            state_q     <= S_HALT;
            halt_stat_q <= STAT_WDOG;
          end else begin
            // Breakpoint checks the committed npc, so PC already sits on the bp address.
            pc_q        <= bus.npc_i;
            instr_cnt_q <= instr_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            commit_q    <= 1'b1;
            if (bp_hit) state_q <= S_BREAK;
          end
        end
        S_BREAK: begin
          if (bus.resume_i) state_q <= S_RUN;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.PC_o        = pc_q;
  assign bus.state_o     = state_q;
  assign bus.run_o       = (state_q == S_RUN);
  assign bus.commit_o    = commit_q;
  assign bus.halt_stat_o = halt_stat_q;
  assign bus.cycle_cnt_o = cycle_cnt_q;
  assign bus.instr_cnt_o = instr_cnt_q;

endmodule
